// File: rtl/track_mixer.sv
// Sequential multi-track mixer: captures one sample per channel on request,
// applies gain/mute, accumulates one channel per clock, emits a saturated mix.
module track_mixer #(
  parameter int WORD_WIDTH = 8,
  parameter int CHANNELS   = 8,
  parameter int GAIN_WIDTH = 4,
  parameter int GAIN_SHIFT = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_req,
  input  logic [CHANNELS*WORD_WIDTH-1:0]   din,
  input  logic [CHANNELS*GAIN_WIDTH-1:0]   gain,
  input  logic [CHANNELS-1:0]              mute,
  output logic signed [WORD_WIDTH-1:0]     dout,
  output logic                             dout_valid,
  output logic                             busy,
  output logic                             clip,
  output logic                             overrun
);

  localparam int IW = $clog2(CHANNELS);
  localparam int PW = WORD_WIDTH + GAIN_WIDTH + 1;
  localparam int AW = WORD_WIDTH + GAIN_WIDTH + IW + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state, state_next;

  logic signed [WORD_WIDTH-1:0] din_q [CHANNELS];
  logic        [GAIN_WIDTH-1:0] gain_q [CHANNELS];
  logic        [CHANNELS-1:0]   mute_q;
  logic        [IW-1:0]         idx;
  logic signed [AW-1:0]         acc;

  logic                         capture;
  logic                         last;
  logic signed [PW-1:0]         prod;
  logic signed [AW-1:0]         acc_next;
  logic signed [AW-1:0]         res;
  logic [AW-WORD_WIDTH:0]       res_hi;
  logic                         sat;
  logic signed [WORD_WIDTH-1:0] res_sat;

  assign capture = sample_req && (state != ACCUM);
  assign last    = (idx == IW'(CHANNELS - 1));
  assign busy    = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_req) state_next = ACCUM;
      ACCUM:   if (last) state_next = DONE;
      DONE:    state_next = sample_req ? ACCUM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result is formed from acc plus the final product so that dout is already
  // registered while the state register shows DONE.
  always_comb begin
    prod = '0;
    if (!mute_q[idx]) begin
      prod = $signed({{(GAIN_WIDTH + 1){din_q[idx][WORD_WIDTH-1]}}, din_q[idx]})
           * $signed({{WORD_WIDTH{1'b0}}, 1'b0, gain_q[idx]});
    end
    acc_next = acc + {{(AW - PW){prod[PW-1]}}, prod};
    res      = acc_next >>> GAIN_SHIFT;
    res_hi   = res[AW-1:WORD_WIDTH-1];
    sat      = !((&res_hi) || (~|res_hi));
    if (!sat)
      res_sat = res[WORD_WIDTH-1:0];
    else if (res[AW-1])
      res_sat = {1'b1, {(WORD_WIDTH - 1){1'b0}}};
    else
      res_sat = {1'b0, {(WORD_WIDTH - 1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        din_q[i]  <= '0;
        gain_q[i] <= '0;
      end
      mute_q     <= '0;
      idx        <= '0;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      clip       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      clip       <= 1'b0;
      overrun    <= sample_req && (state == ACCUM);
      if (capture) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          din_q[i]  <= din[i*WORD_WIDTH +: WORD_WIDTH];
          gain_q[i] <= gain[i*GAIN_WIDTH +: GAIN_WIDTH];
        end
        mute_q <= mute;
        idx    <= '0;
        acc    <= '0;
      end else if (state == ACCUM) begin
        acc <= acc_next;
        idx <= idx + IW'(1);
        if (last) begin
          dout       <= res_sat;
          dout_valid <= 1'b1;
          clip       <= sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_track_mixer.sv
// Directed self-checking bench for track_mixer at default parameters.
module tb_track_mixer;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                sample_req = 1'b0;
  logic [63:0]         din = '0;
  logic [31:0]         gain = '0;
  logic [7:0]          mute = '0;
  logic signed [7:0]   dout;
  logic                dout_valid;
  logic                busy;
  logic                clip;
  logic                overrun;

  int n_checks = 0;
  int n_pass   = 0;

  track_mixer #(
    .WORD_WIDTH (8),
    .CHANNELS   (8),
    .GAIN_WIDTH (4),
    .GAIN_SHIFT (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_req (sample_req),
    .din        (din),
    .gain       (gain),
    .mute       (mute),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .clip       (clip),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic set_all(input int d, input int g, input logic [7:0] m);
    for (int ch = 0; ch < 8; ch++) begin
      din[ch*8 +: 8]  = 8'(d);
      gain[ch*4 +: 4] = 4'(g);
    end
    mute = m;
  endtask

  task automatic set_ch(input int ch, input int d, input int g);
    din[ch*8 +: 8]  = 8'(d);
    gain[ch*4 +: 4] = 4'(g);
  endtask

  // Pulse one request and wait (bounded) for the result; checks latency,
  // busy duration, value, clip and that dout_valid is a single pulse.
  task automatic mix(input string tag, input int exp_dout, input int exp_clip);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    cyc = 1;
    busy_cnt = busy ? 1 : 0;
    while (!dout_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
    end
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_busy_cycles"}, busy_cnt, 9);
    check({tag, "_dout"}, int'(dout), exp_dout);
    check({tag, "_clip"}, int'(clip), exp_clip);
    @(negedge clk);
    check({tag, "_valid_pulse"}, int'(dout_valid), 0);
    check({tag, "_clip_pulse"}, int'(clip), 0);
    check({tag, "_idle"}, int'(busy), 0);
    check({tag, "_hold"}, int'(dout), exp_dout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int extra;
    bit busy_ok;

    // Reset state
    set_all(10, 8, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_dout", int'(dout), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_clip", int'(clip), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b1;

    // Unity mix: 8 * 10 * 8 >>> 3 = 80
    set_all(10, 8, 8'h00);
    mix("unity", 80, 0);

    // Saturation both ways
    set_all(100, 8, 8'h00);
    mix("pos_sat", 127, 1);
    set_all(-128, 8, 8'h00);
    mix("neg_sat", -128, 1);

    // Gain, floor rounding and mute; muted channels carry large data
    set_all(100, 8, 8'hFC);
    set_ch(0, 7, 4);
    set_ch(1, -7, 4);
    mix("cancel", 0, 0);
    mute = 8'hFD;
    mix("floor_neg", -4, 0);
    mute = 8'hFE;
    mix("floor_pos", 3, 0);

    // All gains zero / all muted
    set_all(100, 0, 8'h00);
    mix("zero_gain", 0, 0);
    set_all(-100, 8, 8'hFF);
    mix("all_mute", 0, 0);

    // Overrun: request at T+3 with new din is dropped
    set_all(10, 8, 8'h00);
    @(negedge clk);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ovr_before", int'(overrun), 0);
    sample_req = 1'b1;
    set_all(50, 8, 8'h00);
    @(negedge clk);
    sample_req = 1'b0;
    check("ovr_pulse", int'(overrun), 1);
    @(negedge clk);
    check("ovr_single", int'(overrun), 0);
    cyc = 5;
    while (!dout_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ovr_latency", cyc, 9);
    check("ovr_dout", int'(dout), 80);
    extra = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (dout_valid) extra++;
    end
    check("ovr_no_second", extra, 0);

    // Back-to-back: second request in the DONE cycle
    set_all(10, 8, 8'h00);
    @(negedge clk);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    cyc = 1;
    while (!dout_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_first_latency", cyc, 9);
    check("b2b_first_dout", int'(dout), 80);
    set_all(-5, 8, 8'h00);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    cyc = 1;
    busy_ok = busy;
    while (!dout_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!busy) busy_ok = 1'b0;
    end
    check("b2b_gap", cyc, 9);
    check("b2b_second_dout", int'(dout), -40);
    check("b2b_busy_held", int'(busy_ok), 1);
    @(negedge clk);
    check("b2b_idle", int'(busy), 0);

    // Asynchronous reset mid-ACCUM at T+4
    set_all(20, 8, 8'h00);
    @(negedge clk);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before", int'(busy), 1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_dout", int'(dout), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(dout_valid), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (dout_valid || busy) extra++;
    end
    check("mid_no_result", extra, 0);
    set_all(10, 8, 8'h00);
    mix("post_rst", 80, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
